ramb4_s8_s16_fifo_ctrl: RTL and testbench

Single-clock FIFO controller that sequences one dual-port 512x8 / 256x16 block RAM as a byte-in, halfword-out FIFO. Port A is driven as the 8-bit write port and port B as the 16-bit read port. A two-entry output buffer provides first-word-fall-through ready/valid streams on both sides. The block sits between a byte-serial producer and a 16-bit consumer; the RAM is instantiated beside it and wired to the RAM_* ports.

---
 rtl/ramb4_s8_s16_fifo_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_ramb4_s8_s16_fifo_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ramb4_s8_s16_fifo_ctrl.sv
// ramb4_s8_s16_fifo_ctrl
//
// Byte-in / halfword-out FIFO controller for one dual-port 512x8 / 256x16
// block RAM. Port A is the 8-bit write port and port B is the 16-bit read
// port. Bytes are packed little-endian: byte 2k lands in DOB[7:0] of word k
// and byte 2k+1 lands in DOB[15:8]. A two-entry output buffer gives
// first-word-fall-through behaviour on the read side.
//
// Optional build macro: FIFO_ODD_PAD_EN
//   When defined, input PAD_REQ lets the producer complete a half-written
//   word with a 0x00 high byte so that an odd trailing byte can drain.
//
// Ports
//   CLK, RST_N            clock, asynchronous active-low reset
//   FLUSH                 synchronous clear of all FIFO state
//   WR_VALID/WR_DATA/WR_READY   8-bit input stream
//   PAD_REQ               (FIFO_ODD_PAD_EN only) pad request
//   RD_VALID/RD_DATA/RD_READY   16-bit output stream
//   OCC                   bytes held in RAM, including an in-flight fetch
//   RD_LEVEL              complete words in RAM plus buffered words
//   AFULL, AEMPTY         level flags (OCC >= AFULL_THRESH,
//                         RD_LEVEL <= AEMPTY_THRESH)
//   RAM_*                 block RAM port A (write) / port B (read) drive

module ramb4_s8_s16_fifo_ctrl #(
  parameter int unsigned AFULL_THRESH  = 480,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        FLUSH,
  input  logic        WR_VALID,
  input  logic [7:0]  WR_DATA,
  output logic        WR_READY,
`ifdef FIFO_ODD_PAD_EN
  input  logic        PAD_REQ,
`endif
  output logic        RD_VALID,
  output logic [15:0] RD_DATA,
  input  logic        RD_READY,
  output logic [9:0]  OCC,
  output logic [8:0]  RD_LEVEL,
  output logic        AFULL,
  output logic        AEMPTY,
  output logic [8:0]  RAM_ADDRA,
  output logic [7:0]  RAM_DIA,
  output logic        RAM_ENA,
  output logic        RAM_WEA,
  output logic        RAM_RSTA,
  output logic [7:0]  RAM_ADDRB,
  output logic        RAM_ENB,
  output logic        RAM_WEB,
  output logic        RAM_RSTB,
  input  logic [15:0] RAM_DOB
);

  localparam logic [9:0] AFULL_LVL  = AFULL_THRESH[9:0];
  localparam logic [8:0] AEMPTY_LVL = AEMPTY_THRESH[8:0];

  // Registered state
  logic        rst_done_q, rst_done_d;
  logic [8:0]  wr_ptr_q, wr_ptr_d;        // byte address, port A
  logic [7:0]  rd_ptr_q, rd_ptr_d;        // word address, port B
  logic [9:0]  occ_q, occ_d;              // bytes in RAM incl. in-flight word
  logic        inflight_q, inflight_d;    // port B read issued last cycle
  logic [15:0] obuf_q [2];
  logic [15:0] obuf_d [2];
  logic        obuf_wr_q, obuf_wr_d;
  logic        obuf_rd_q, obuf_rd_d;
  logic [1:0]  obuf_cnt_q, obuf_cnt_d;

  // Per-cycle control
  logic        base_ready;
  logic        pad_wr;
  logic        wr_accept;
  logic        ram_wr;
  logic        pop;
  logic        issue;
  logic        capture;
  logic        word_avail;
  logic [9:0]  unfetched;
  logic [2:0]  slots;

  always_comb begin
    // OCC never exceeds 512, so bit 9 set means exactly full.
    base_ready = rst_done_q & ~occ_q[9] & ~FLUSH;
`ifdef FIFO_ODD_PAD_EN
    // A real write always wins over padding; an odd OCC implies space.
    pad_wr     = PAD_REQ & occ_q[0] & base_ready & ~WR_VALID;
`else
    pad_wr     = 1'b0;
`endif
    WR_READY   = base_ready & ~pad_wr;
    wr_accept  = WR_VALID & WR_READY;
    ram_wr     = wr_accept | pad_wr;

    RD_VALID   = (obuf_cnt_q != 2'd0);
    RD_DATA    = obuf_q[obuf_rd_q];
    pop        = RD_VALID & RD_READY;

    // The in-flight word is still counted in OCC but is no longer fetchable.
    // Because OCC is registered, a word only becomes fetchable once both of
    // its bytes were written at an earlier edge.
    unfetched  = occ_q - {8'd0, inflight_q, 1'b0};
    word_avail = (unfetched > 10'd1);

    // Buffered words plus the word in flight must leave room after this
    // cycle's pop; this keeps the two-entry buffer from overflowing while
    // still allowing one fetch per cycle under continuous reads.
    slots      = {1'b0, obuf_cnt_q} + {2'b00, inflight_q};
    issue      = ~FLUSH & word_avail & ((slots < 3'd2) | pop);

    // A flush discards whatever port B returns this cycle.
    capture    = inflight_q & ~FLUSH;
  end

  always_comb begin
    rst_done_d = 1'b1;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    inflight_d = inflight_q;
    obuf_d[0]  = obuf_q[0];
    obuf_d[1]  = obuf_q[1];
    obuf_wr_d  = obuf_wr_q;
    obuf_rd_d  = obuf_rd_q;
    obuf_cnt_d = obuf_cnt_q;

    if (FLUSH) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      occ_d      = '0;
      inflight_d = 1'b0;
      obuf_d[0]  = '0;
      obuf_d[1]  = '0;
      obuf_wr_d  = 1'b0;
      obuf_rd_d  = 1'b0;
      obuf_cnt_d = '0;
    end else begin
      if (ram_wr) begin
        wr_ptr_d = wr_ptr_q + 9'd1;
      end
      if (issue) begin
        rd_ptr_d = rd_ptr_q + 8'd1;
      end
      inflight_d = issue;

      // Space is released only at capture, so a word being fetched can
      // never be overwritten by port A in the same cycle.
      occ_d = occ_q + {9'd0, ram_wr} - {8'd0, capture, 1'b0};

      if (capture) begin
        obuf_d[obuf_wr_q] = RAM_DOB;
        obuf_wr_d         = ~obuf_wr_q;
      end
      if (pop) begin
        obuf_rd_d = ~obuf_rd_q;
      end
      obuf_cnt_d = obuf_cnt_q + {1'b0, capture} - {1'b0, pop};
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rst_done_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      inflight_q <= 1'b0;
      obuf_q[0]  <= '0;
      obuf_q[1]  <= '0;
      obuf_wr_q  <= 1'b0;
      obuf_rd_q  <= 1'b0;
      obuf_cnt_q <= '0;
    end else begin
      rst_done_q <= rst_done_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      obuf_q[0]  <= obuf_d[0];
      obuf_q[1]  <= obuf_d[1];
      obuf_wr_q  <= obuf_wr_d;
      obuf_rd_q  <= obuf_rd_d;
      obuf_cnt_q <= obuf_cnt_d;
    end
  end

  // Status outputs. RD_LEVEL peaks at 256 + 2 and fits in 9 bits.
  assign OCC      = occ_q;
  assign RD_LEVEL = occ_q[9:1] + {7'd0, obuf_cnt_q};
  assign AFULL    = (occ_q >= AFULL_LVL);
  assign AEMPTY   = (RD_LEVEL <= AEMPTY_LVL);

  // RAM drive
  assign RAM_ADDRA = wr_ptr_q;
  assign RAM_DIA   = pad_wr ? 8'h00 : WR_DATA;
  assign RAM_ENA   = ram_wr;
  assign RAM_WEA   = ram_wr;
  assign RAM_RSTA  = 1'b0;
  assign RAM_ADDRB = rd_ptr_q;
  assign RAM_ENB   = issue;
  assign RAM_WEB   = 1'b0;
  assign RAM_RSTB  = 1'b0;

endmodule

// File: tb/tb_ramb4_s8_s16_fifo_ctrl.sv
// Testbench for ramb4_s8_s16_fifo_ctrl: a behavioural 512x8 / 256x16 RAM,
// a per-cycle vector table for the basic pairing/latency sequence, and a
// scoreboard that pairs accepted bytes into expected halfwords.
// Build with FIFO_ODD_PAD_EN defined to exercise the pad path.

module tb_ramb4_s8_s16_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        wr_valid;
  logic [7:0]  wr_data;
  logic        wr_ready;
`ifdef FIFO_ODD_PAD_EN
  logic        pad_req;
`endif
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        rd_ready;
  logic [9:0]  occ;
  logic [8:0]  rd_level;
  logic        afull, aempty;
  logic [8:0]  ram_addra;
  logic [7:0]  ram_dia;
  logic        ram_ena, ram_wea, ram_rsta;
  logic [7:0]  ram_addrb;
  logic        ram_enb, ram_web, ram_rstb;
  logic [15:0] ram_dob;

  always #5 clk = ~clk;

  ramb4_s8_s16_fifo_ctrl #(
    .AFULL_THRESH (480),
    .AEMPTY_THRESH(2)
  ) dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .FLUSH    (flush),
    .WR_VALID (wr_valid),
    .WR_DATA  (wr_data),
    .WR_READY (wr_ready),
`ifdef FIFO_ODD_PAD_EN
    .PAD_REQ  (pad_req),
`endif
    .RD_VALID (rd_valid),
    .RD_DATA  (rd_data),
    .RD_READY (rd_ready),
    .OCC      (occ),
    .RD_LEVEL (rd_level),
    .AFULL    (afull),
    .AEMPTY   (aempty),
    .RAM_ADDRA(ram_addra),
    .RAM_DIA  (ram_dia),
    .RAM_ENA  (ram_ena),
    .RAM_WEA  (ram_wea),
    .RAM_RSTA (ram_rsta),
    .RAM_ADDRB(ram_addrb),
    .RAM_ENB  (ram_enb),
    .RAM_WEB  (ram_web),
    .RAM_RSTB (ram_rstb),
    .RAM_DOB  (ram_dob)
  );

  // Behavioural block RAM: byte-wide port A, halfword-wide synchronous port B.
  logic [7:0] mem [512];
  always @(posedge clk) begin
    if (ram_ena && ram_wea) mem[ram_addra] <= ram_dia;
    if (ram_enb) ram_dob <= {mem[{ram_addrb, 1'b1}], mem[{ram_addrb, 1'b0}]};
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: accepted bytes pair up into expected words, compared on pop.
  logic [15:0] exp_q [$];
  logic        have_lo = 1'b0;
  logic [7:0]  lo_byte;
  logic        stall_prev = 1'b0;
  logic [15:0] stall_data;

  task automatic push_byte(input logic [7:0] b);
    if (!have_lo) begin
      lo_byte = b;
      have_lo = 1'b1;
    end else begin
      exp_q.push_back({b, lo_byte});
      have_lo = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (flush) begin
        exp_q.delete();
        have_lo    = 1'b0;
        stall_prev = 1'b0;
      end else begin
        if (rd_valid && rd_ready) begin
          if (exp_q.size() == 0) chk("pop_unexpected", 1, 0);
          else chk("sb_rd_data", rd_data, exp_q.pop_front());
        end
        if (stall_prev) chk("stall_hold", {rd_valid, rd_data}, {1'b1, stall_data});
        stall_prev = rd_valid && !rd_ready;
        stall_data = rd_data;
        if (wr_valid && wr_ready) push_byte(wr_data);
`ifdef FIFO_ODD_PAD_EN
        else if (pad_req && !wr_valid && have_lo) push_byte(8'h00);
`endif
      end
    end
  end

  task automatic even_up();
    rd_ready = 1'b1;
    if (have_lo) begin
      wr_valid = 1'b1;
      wr_data  = 8'hC3;
      for (int c = 0; c < 100; c++) begin
        #1;
        if (wr_ready) begin
          step();
          break;
        end
        step();
      end
      wr_valid = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    for (int c = 0; c < 1200; c++) begin
      #1;
      if (exp_q.size() == 0 && !rd_valid && occ == 10'd0) break;
      step();
    end
    chk({name, "_sb_empty"}, exp_q.size(), 0);
    chk({name, "_occ"}, occ, 0);
  endtask

  typedef struct {
    logic        wv;
    logic [7:0]  wd;
    logic        rr;
    logic        e_wrdy;
    logic        e_rvld;
    logic [15:0] e_rdata;
    logic [9:0]  e_occ;
    logic [8:0]  e_lvl;
    logic        e_ena;
    logic        e_enb;
  } vec_t;

  vec_t vecs [16];

  initial begin
    int  n;
    logic seen, got, full_seen;
    logic afl_lo, afl_hi, aem_lo, aem_hi;

    //          wv  wd     rr  wrdy rvld rdata     occ lvl ena enb
    vecs[0]  = '{1, 8'h34, 1,  1,   0,   16'h0,    0,  0,  1,  0};
    vecs[1]  = '{1, 8'h12, 1,  1,   0,   16'h0,    1,  0,  1,  0};
    vecs[2]  = '{0, 8'h00, 1,  1,   0,   16'h0,    2,  1,  0,  1};
    vecs[3]  = '{0, 8'h00, 1,  1,   0,   16'h0,    2,  1,  0,  0};
    vecs[4]  = '{0, 8'h00, 1,  1,   1,   16'h1234, 0,  1,  0,  0};
    vecs[5]  = '{0, 8'h00, 1,  1,   0,   16'h0,    0,  0,  0,  0};
    vecs[6]  = '{1, 8'hAA, 1,  1,   0,   16'h0,    0,  0,  1,  0};
    vecs[7]  = '{0, 8'h00, 1,  1,   0,   16'h0,    1,  0,  0,  0};
    vecs[8]  = '{0, 8'h00, 1,  1,   0,   16'h0,    1,  0,  0,  0};
    vecs[9]  = '{1, 8'hBB, 1,  1,   0,   16'h0,    1,  0,  1,  0};
    vecs[10] = '{0, 8'h00, 0,  1,   0,   16'h0,    2,  1,  0,  1};
    vecs[11] = '{0, 8'h00, 0,  1,   0,   16'h0,    2,  1,  0,  0};
    vecs[12] = '{0, 8'h00, 0,  1,   1,   16'hBBAA, 0,  1,  0,  0};
    vecs[13] = '{0, 8'h00, 0,  1,   1,   16'hBBAA, 0,  1,  0,  0};
    vecs[14] = '{0, 8'h00, 1,  1,   1,   16'hBBAA, 0,  1,  0,  0};
    vecs[15] = '{0, 8'h00, 1,  1,   0,   16'h0,    0,  0,  0,  0};

    rst_n = 1'b0; flush = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
`ifdef FIFO_ODD_PAD_EN
    pad_req = 1'b0;
`endif

    // Reset state
    repeat (3) step();
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_occ", occ, 0);
    chk("rst_rd_level", rd_level, 0);
    chk("rst_afull", afull, 0);
    chk("rst_aempty", aempty, 1);
    chk("rst_ram_en", {ram_ena, ram_wea, ram_enb, ram_web}, 0);
    rst_n = 1'b1;
    #1;
    chk("wr_ready_before_edge", wr_ready, 0);
    step();
    chk("wr_ready_after_release", wr_ready, 1);

    // Byte pairing, latency, odd-byte hold and stall, cycle by cycle
    for (int i = 0; i < 16; i++) begin
      wr_valid = vecs[i].wv;
      wr_data  = vecs[i].wd;
      rd_ready = vecs[i].rr;
      #1;
      chk($sformatf("vec%0d_wr_ready", i), wr_ready, vecs[i].e_wrdy);
      chk($sformatf("vec%0d_rd_valid", i), rd_valid, vecs[i].e_rvld);
      if (vecs[i].e_rvld) chk($sformatf("vec%0d_rd_data", i), rd_data, vecs[i].e_rdata);
      chk($sformatf("vec%0d_occ", i), occ, vecs[i].e_occ);
      chk($sformatf("vec%0d_rd_level", i), rd_level, vecs[i].e_lvl);
      chk($sformatf("vec%0d_ram_ena", i), ram_ena, vecs[i].e_ena);
      chk($sformatf("vec%0d_ram_enb", i), ram_enb, vecs[i].e_enb);
      step();
    end
    wr_valid = 1'b0;

    // Fill to full with reads stalled: 512 bytes in RAM plus 2 buffered words
    rd_ready = 1'b0; wr_valid = 1'b1; n = 0; full_seen = 1'b0;
    afl_lo = 1'b0; afl_hi = 1'b0; aem_lo = 1'b0; aem_hi = 1'b0;
    for (int c = 0; c < 800; c++) begin
      wr_data = n[7:0];
      #1;
      if (occ == 10'd479 && !afl_lo) begin chk("afull_at_479", afull, 0); afl_lo = 1'b1; end
      if (occ == 10'd480 && !afl_hi) begin chk("afull_at_480", afull, 1); afl_hi = 1'b1; end
      if (rd_level == 9'd2 && !aem_lo) begin chk("aempty_at_2", aempty, 1); aem_lo = 1'b1; end
      if (rd_level == 9'd3 && !aem_hi) begin chk("aempty_at_3", aempty, 0); aem_hi = 1'b1; end
      if (!wr_ready) begin full_seen = 1'b1; break; end
      n++;
      step();
    end
    chk("full_reached", full_seen, 1);
    chk("full_accept_count", n, 516);
    chk("full_occ", occ, 512);
    chk("full_afull", afull, 1);
    chk("full_rd_level", rd_level, 258);
    chk("full_aempty", aempty, 0);

    // WR_READY recovers one cycle after the first capture
    wr_valid = 1'b0; rd_ready = 1'b1;
    #1;
    chk("full_pop_enb", ram_enb, 1);
    chk("full_pop_occ", occ, 512);
    step();
    chk("full_wr_ready_pre_capture", wr_ready, 0);
    step();
    chk("full_occ_after_capture", occ, 510);
    chk("full_wr_ready_after_capture", wr_ready, 1);

    // Stream through the pointer wrap while draining
    wr_valid = 1'b1;
    for (int c = 0; c < 700; c++) begin
      wr_data = 8'(c) ^ 8'h5A;
      step();
    end
    wr_valid = 1'b0;
    even_up();
    drain("drain_wrap");

    // Random producer and consumer backpressure
    for (int c = 0; c < 1500; c++) begin
      wr_valid = ($urandom_range(0, 3) != 0);
      wr_data  = 8'($urandom);
      rd_ready = ($urandom_range(0, 1) == 1);
      step();
    end
    wr_valid = 1'b0;
    even_up();
    drain("drain_random");

    // Flush in the capture cycle of a fetch
    rd_ready = 1'b1;
    wr_valid = 1'b1; wr_data = 8'h55; step();
    wr_data = 8'h66; step();
    wr_valid = 1'b0;
    #1;
    chk("flush_pre_enb", ram_enb, 1);
    step();
    flush = 1'b1; wr_valid = 1'b1; wr_data = 8'h77;
    #1;
    chk("flush_no_ram_en", {ram_ena, ram_enb}, 0);
    chk("flush_wr_ready", wr_ready, 0);
    step();
    flush = 1'b0; wr_valid = 1'b0;
    #1;
    chk("post_flush_rd_valid", rd_valid, 0);
    chk("post_flush_occ", occ, 0);
    chk("post_flush_rd_level", rd_level, 0);
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (rd_valid) seen = 1'b1;
      step();
    end
    chk("flushed_word_never_shown", seen, 0);
    wr_valid = 1'b1; wr_data = 8'h21; step();
    wr_data = 8'h43; step();
    drain("drain_after_flush");

    // Odd trailing byte
    rd_ready = 1'b1;
    wr_valid = 1'b1; wr_data = 8'hAB; step();
    wr_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (rd_valid || ram_enb) seen = 1'b1;
      step();
    end
    chk("odd_byte_no_output", seen, 0);
    chk("odd_byte_occ", occ, 1);
`ifdef FIFO_ODD_PAD_EN
    pad_req = 1'b1;
    #1;
    chk("pad_wr_ready", wr_ready, 0);
    chk("pad_ram_ena", ram_ena, 1);
    chk("pad_ram_dia", ram_dia, 0);
    step();
    pad_req = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (rd_valid) begin got = 1'b1; break; end
      step();
    end
    chk("pad_valid", got, 1);
    chk("pad_word", rd_data, 16'h00AB);
    drain("drain_pad");
`else
    got = 1'b0;
    flush = 1'b1; step();
    flush = 1'b0;
    #1;
    chk("odd_flush_occ", occ, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
